// File: rtl/uart_sid_tx_if.sv
// RIB slave bus bundle for uart_sid_tx: single-cycle request, combinational read data.
interface uart_sid_tx_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output req_i, we_i, addr_i, data_i, input data_o);
    modport slave  (input req_i, we_i, addr_i, data_i, output data_o);
endinterface

// File: rtl/uart_sid_tx.sv
// UART transmitter that sends a software-loaded 1..8 byte ID string, 8N1 LSB first.
// Define UART_SID_PARITY_EN to insert an even-parity bit before STOP (8E1 framing).
module uart_sid_tx #(
    parameter logic [15:0] DEFAULT_BAUD = 16'd434
) (
    input  logic          clk,
    input  logic          rst,
    uart_sid_tx_if.slave  bus,
    output logic          tx_pin,
    output logic          sid_compl_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_SID_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [3:0]  len_q, len_d;
    logic [31:0] id0_q, id0_d;
    logic [31:0] id1_q, id1_d;
    logic        done_q, done_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic        tx_q, tx_d;

    logic        wr, busy, start_acc, w1c_done, done_set, done_clr, bit_done;
    logic [2:0]  off;
    logic [63:0] id_all;
    logic [7:0]  cur_byte;
    logic [3:0]  len_eff, idx_nxt;
    logic [15:0] reload;
    logic [2:0]  nxt_bit;
    logic        unused_bits;

    assign unused_bits = ^{bus.addr_i[31:5], bus.addr_i[1:0]};

    always_comb begin
        wr       = bus.req_i & bus.we_i;
        off      = bus.addr_i[4:2];
        busy     = (state_q != S_IDLE);
        id_all   = {id1_q, id0_q};
        cur_byte = id_all[{byte_idx_q[2:0], 3'b000} +: 8];
        len_eff  = (len_q > 4'd8) ? 4'd8 : len_q;
        reload   = (baud_q < 16'd2) ? 16'd1 : baud_q - 16'd1;
        bit_done = (baud_cnt_q == 16'd0);
        idx_nxt  = byte_idx_q + 4'd1;
        nxt_bit  = bit_cnt_q + 3'd1;

        start_acc = wr && (off == 3'd0) && bus.data_i[0] && !busy;
        w1c_done  = wr && (off == 3'd1) && bus.data_i[1];
        done_set  = 1'b0;
        done_clr  = 1'b0;

        state_d    = state_q;
        baud_d     = baud_q;
        len_d      = len_q;
        id0_d      = id0_q;
        id1_d      = id1_q;
        byte_idx_d = byte_idx_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        baud_cnt_d = baud_cnt_q;

        // Configuration is frozen while a string is on the wire.
        if (wr && !busy) begin
            case (off)
                3'd2: baud_d = bus.data_i[15:0];
                3'd3: id0_d  = bus.data_i;
                3'd4: id1_d  = bus.data_i;
                3'd5: len_d  = bus.data_i[3:0];
                default: ;
            endcase
        end

        if (busy)
            baud_cnt_d = bit_done ? reload : baud_cnt_q - 16'd1;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (start_acc) begin
                    if (len_eff != 4'd0) begin
                        state_d    = S_START;
                        tx_d       = 1'b0;
                        byte_idx_d = 4'd0;
                        baud_cnt_d = reload;
                        done_clr   = 1'b1;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                    tx_d      = cur_byte[0];
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_SID_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = ^cur_byte;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = nxt_bit;
                        tx_d      = cur_byte[nxt_bit];
                    end
                end
            end
`ifdef UART_SID_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    byte_idx_d = idx_nxt;
                    if (idx_nxt == len_eff) begin
                        state_d  = S_IDLE;
                        done_set = 1'b1;
                    end else begin
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // A completion landing on the same edge as a W1C must not be lost.
        done_d = done_q;
        if (w1c_done || done_clr)
            done_d = 1'b0;
        if (done_set)
            done_d = 1'b1;

        bus.data_o = 32'd0;
        if (bus.req_i) begin
            case (off)
                3'd1: bus.data_o = {30'd0, done_q, busy};
                3'd2: bus.data_o = {16'd0, baud_q};
                3'd3: bus.data_o = id0_q;
                3'd4: bus.data_o = id1_q;
                3'd5: bus.data_o = {28'd0, len_q};
                default: bus.data_o = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= DEFAULT_BAUD;
            len_q      <= 4'd0;
            id0_q      <= 32'd0;
            id1_q      <= 32'd0;
            done_q     <= 1'b0;
            byte_idx_q <= 4'd0;
            bit_cnt_q  <= 3'd0;
            baud_cnt_q <= 16'd0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            len_q      <= len_d;
            id0_q      <= id0_d;
            id1_q      <= id1_d;
            done_q     <= done_d;
            byte_idx_q <= byte_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            tx_q       <= tx_d;
        end
    end

    assign tx_pin      = tx_q;
    assign sid_compl_o = done_q;

endmodule
